// File: rtl/ysyx_22040237_mdu_ctrl.sv
// Purpose: RV64M multiply/divide sequencer (shift-add multiplier, restoring divider), one op in flight.
// Latency: accept to resp_valid_o is N+2 cycles (N=64, or 32 for word ops); divide-by-zero/overflow is 1 cycle.
// Backpressure: result is held in DONE until resp_ready_i; req_ready_o is low whenever busy_o is high.
module ysyx_22040237_mdu_ctrl #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      op_i,
   input  logic            wop_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [4:0]      rd_idx_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] res_o,
   output logic [4:0]      rd_idx_o,
   output logic            rd_wr_en_o,
   output logic            busy_o
);
   localparam int DW = 2 * XLEN;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            wop_q, wop_d;
   logic            neg_q, neg_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] a_q, a_d;     // multiplier (shifts right) / dividend shifting out, quotient shifting in
   logic [DW-1:0]   b_q, b_d;     // multiplicand (shifts left) / divisor in the low half
   logic [DW-1:0]   acc_q, acc_d; // product / partial remainder in the low half
   logic [XLEN-1:0] res_q, res_d;

   logic            wop_eff, s1_signed, s2_signed, s1, s2, neg_in, div_zero, div_ovf;
   logic [XLEN-1:0] op1_ext, op2_ext, mag1, mag2, spec_res;
   logic [XLEN:0]   rem_sh, rem_diff;
   logic [DW-1:0]   prod_fix;
   logic [XLEN-1:0] quot_fix, rem_fix, sel_res;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   // Operand preparation: width/sign extension, magnitudes, result sign and special-case detection.
   always_comb begin
      wop_eff   = wop_i & (op_i[2] | (op_i[1:0] == 2'b00));
      s1_signed = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
      s2_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
      op1_ext   = op1_i;
      op2_ext   = op2_i;
      if (wop_eff) begin
         op1_ext = s1_signed ? sext32(op1_i[31:0]) : {{(XLEN-32){1'b0}}, op1_i[31:0]};
         op2_ext = s2_signed ? sext32(op2_i[31:0]) : {{(XLEN-32){1'b0}}, op2_i[31:0]};
      end
      s1       = s1_signed & op1_ext[XLEN-1];
      s2       = s2_signed & op2_ext[XLEN-1];
      mag1     = s1 ? -op1_ext : op1_ext;
      mag2     = s2 ? -op2_ext : op2_ext;
      // remainder takes the dividend's sign; everything else the product/quotient sign
      neg_in   = (op_i[2] & op_i[1]) ? s1 : (s1 ^ s2);
      div_zero = op_i[2] & (op2_ext == '0);
      if (wop_eff)
         div_ovf = op_i[2] & ~op_i[0] & (op1_i[31:0] == 32'h8000_0000) & (op2_i[31:0] == 32'hFFFF_FFFF);
      else
         div_ovf = op_i[2] & ~op_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
      if (div_zero)
         spec_res = op_i[1] ? op1_ext : '1;
      else
         spec_res = op_i[1] ? '0 : op1_ext;
      if (wop_eff)
         spec_res = sext32(spec_res[31:0]);
   end

   // Next-state, iteration datapath and result fix-up.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      wop_d    = wop_q;
      neg_d    = neg_q;
      rd_d     = rd_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      res_d    = res_q;
      rem_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
      rem_diff = rem_sh - {1'b0, b_q[XLEN-1:0]};
      prod_fix = neg_q ? -acc_q : acc_q;
      quot_fix = neg_q ? -a_q : a_q;
      rem_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      case (op_q)
         3'b000:                 sel_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: sel_res = prod_fix[DW-1:XLEN];
         3'b100, 3'b101:         sel_res = quot_fix;
         default:                sel_res = rem_fix;
      endcase
      if (wop_q)
         sel_res = sext32(sel_res[31:0]);

      case (state_q)
         S_IDLE: begin
            if (req_valid_i && !flush_i) begin
               op_d  = op_i;
               wop_d = wop_eff;
               neg_d = neg_in;
               rd_d  = rd_idx_i;
               cnt_d = wop_eff ? 6'd31 : 6'd63;
               acc_d = '0;
               b_d   = {{XLEN{1'b0}}, mag2};
               // word divides align the 32-bit dividend to the top so it shifts out first
               a_d   = (op_i[2] & wop_eff) ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;
               if (div_zero || div_ovf) begin
                  res_d   = spec_res;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (!op_q[2]) begin
               if (a_q[0])
                  acc_d = acc_q + b_q;
               b_d = b_q << 1;
               a_d = a_q >> 1;
            end else begin
               // a negative trial difference means restore (keep the shifted remainder)
               acc_d = {{XLEN{1'b0}}, (rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0])};
               a_d   = {a_q[XLEN-2:0], ~rem_diff[XLEN]};
            end
            if (cnt_q == 6'd0)
               state_d = S_FIX;
            else
               cnt_d = cnt_q - 6'd1;
         end
         S_FIX: begin
            res_d   = sel_res;
            state_d = S_DONE;
         end
         default: begin
            if (resp_ready_i)
               state_d = S_IDLE;
         end
      endcase

      if (flush_i)
         state_d = S_IDLE;
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         wop_q   <= 1'b0;
         neg_q   <= 1'b0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         wop_q   <= wop_d;
         neg_q   <= neg_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign busy_o       = (state_q != S_IDLE);
   assign resp_valid_o = (state_q == S_DONE);
   assign rd_wr_en_o   = resp_valid_o;
   assign res_o        = res_q;
   assign rd_idx_o     = rd_q;
endmodule

// File: tb/tb_ysyx_22040237_mdu_ctrl.sv
// Bench for the RV64M multiply/divide sequencer: literal cases, random ops against a reference model,
// backpressure, flush and mid-operation reset.
module tb_ysyx_22040237_mdu_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o;
   logic [2:0]  op_i;
   logic        wop_i;
   logic [63:0] op1_i, op2_i;
   logic [4:0]  rd_idx_i;
   logic        flush_i;
   logic        resp_valid_o, resp_ready_i;
   logic [63:0] res_o;
   logic [4:0]  rd_idx_o;
   logic        rd_wr_en_o, busy_o;

   int n_vec = 0;
   int n_bad = 0;

   ysyx_22040237_mdu_ctrl #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .op_i(op_i), .wop_i(wop_i), .op1_i(op1_i), .op2_i(op2_i), .rd_idx_i(rd_idx_i),
      .flush_i(flush_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .res_o(res_o), .rd_idx_o(rd_idx_o), .rd_wr_en_o(rd_wr_en_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // RISC-V M-extension result computed directly from the ISA rules.
   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
      logic             weff;
      logic [127:0]     ea, eb, p;
      int               x, y;
      int unsigned      ux, uy;
      longint           sa, sb;
      longint unsigned  ua, ub;
      logic [63:0]      r;
      weff = w && (op[2] || op[1:0] == 2'b00);
      x = a[31:0]; y = b[31:0]; ux = a[31:0]; uy = b[31:0];
      sa = a; sb = b; ua = a; ub = b;
      ea = (op == 3'd3) ? {64'd0, a} : {{64{a[63]}}, a};
      eb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      r  = '0;
      case (op)
         3'd0: r = a * b;
         3'd1, 3'd2, 3'd3: r = p[127:64];
         3'd4: begin
            if (weff) begin
               if (y == 0) r = '1;
               else if (ux == 32'h8000_0000 && y == -1) r = a;
               else r = 64'(x / y);
            end else begin
               if (sb == 0) r = '1;
               else if (ua == 64'h8000_0000_0000_0000 && sb == -1) r = a;
               else r = sa / sb;
            end
         end
         3'd5: begin
            if (weff) r = (uy == 0) ? '1 : 64'(ux / uy);
            else      r = (ub == 0) ? '1 : ua / ub;
         end
         3'd6: begin
            if (weff) begin
               if (y == 0) r = a;
               else if (ux == 32'h8000_0000 && y == -1) r = '0;
               else r = 64'(x % y);
            end else begin
               if (sb == 0) r = a;
               else if (ua == 64'h8000_0000_0000_0000 && sb == -1) r = '0;
               else r = sa % sb;
            end
         end
         default: begin
            if (weff) r = (uy == 0) ? a : 64'(ux % uy);
            else      r = (ub == 0) ? a : ua % ub;
         end
      endcase
      if (weff) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   // Cycles from the accepting edge to the first cycle with a valid response.
   function automatic int ref_lat(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
      logic weff, zero, ovf;
      weff = w && (op[2] || op[1:0] == 2'b00);
      if (op[2]) begin
         zero = weff ? (b[31:0] == 32'd0) : (b == 64'd0);
         ovf  = !op[0] && (weff ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                : (a == 64'h8000_0000_0000_0000 && b == '1));
         if (zero || ovf) return 1;
      end
      return weff ? 34 : 66;
   endfunction

   function automatic logic [63:0] pick();
      logic [63:0] v;
      case ($urandom % 7)
         0: v = 64'd0;
         1: v = '1;
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'($urandom_range(0, 20));
         4: v = {$urandom, 32'h8000_0000};
         5: v = {$urandom, 32'hFFFF_FFFF};
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_req_ready"}, req_ready_o, 1);
      chk({tag, "_resp_valid"}, resp_valid_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_res"}, res_o, 0);
      chk({tag, "_rd_idx"}, rd_idx_o, 0);
      chk({tag, "_rd_wr_en"}, rd_wr_en_o, 0);
   endtask

   task automatic accept(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
      @(negedge clk);
      chk("req_ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1; op_i = op; wop_i = w; op1_i = a; op2_i = b; rd_idx_i = rd;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      op_i = 3'($urandom); wop_i = 1'($urandom);
      op1_i = {$urandom, $urandom}; op2_i = {$urandom, $urandom}; rd_idx_i = ~rd;
   endtask

   task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input int hold, input logic [63:0] want);
      int lat;
      lat = ref_lat(op, w, a, b);
      accept(op, w, a, b, rd);
      for (int c = 1; c < lat; c++) begin
         @(negedge clk);
         chk("busy_in_flight", busy_o, 1);
         chk("resp_valid_early", resp_valid_o, 0);
         chk("req_ready_in_flight", req_ready_o, 0);
      end
      @(negedge clk);
      chk("resp_valid_at_latency", resp_valid_o, 1);
      chk("res", res_o, want);
      chk("rd_idx", rd_idx_o, rd);
      chk("rd_wr_en", rd_wr_en_o, 1);
      if (resp_valid_o !== 1'b1) begin
         rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("res_stable_bp", res_o, want);
         chk("resp_valid_bp", resp_valid_o, 1);
         chk("req_ready_bp", req_ready_o, 0);
      end
      resp_ready_i = 1'b1;
      @(posedge clk); #1;
      resp_ready_i = 1'b0;
      @(negedge clk);
      chk("resp_valid_after_hs", resp_valid_o, 0);
      chk("req_ready_after_hs", req_ready_o, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  rop;
      logic        rw;
      logic [63:0] ra, rb;
      logic [4:0]  rrd;
      bit          saw;

      rst = 1'b0; req_valid_i = 1'b0; op_i = '0; wop_i = 1'b0; op1_i = '0; op2_i = '0;
      rd_idx_i = '0; flush_i = 1'b0; resp_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b1;

      // hand-computed cases
      do_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7, 5, 64'hFFFF_FFFF_FFFF_FFF1);
      do_op(3'd3, 1'b0, '1, '1, 5'd9, 0, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(3'd1, 1'b0, '1, '1, 5'd10, 0, 64'd0);
      do_op(3'd4, 1'b0, 64'd7, 64'd0, 5'd11, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op(3'd6, 1'b0, 64'd7, 64'd0, 5'd12, 0, 64'd7);
      do_op(3'd5, 1'b1, 64'd5, 64'd0, 5'd13, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd14, 0, 64'h8000_0000_0000_0000);
      do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd15, 0, 64'd0);
      do_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd16, 0, 64'hFFFF_FFFF_8000_0000);
      do_op(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd17, 2, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd18, 0, 64'hFFFF_FFFF_FFFF_FFFF);

      // randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom); rw = 1'($urandom); ra = pick(); rb = pick(); rrd = 5'($urandom);
         do_op(rop, rw, ra, rb, rrd, $urandom_range(0, 3), ref_res(rop, rw, ra, rb));
      end

      // flush at CALC cycle 10
      accept(3'd0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd21);
      repeat (10) @(negedge clk);
      chk("busy_before_flush", busy_o, 1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_calc_ready", req_ready_o, 1);
      chk("flush_calc_busy", busy_o, 0);
      saw = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (resp_valid_o !== 1'b0) saw = 1'b1;
      end
      chk("flush_calc_no_resp", saw, 0);

      // flush and accept in the same cycle: nothing accepted
      @(negedge clk);
      req_valid_i = 1'b1; op_i = 3'd0; wop_i = 1'b0; op1_i = 64'd3; op2_i = 64'd5; rd_idx_i = 5'd3; flush_i = 1'b1;
      @(posedge clk); #1;
      req_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("flush_accept_busy", busy_o, 0);
      chk("flush_accept_ready", req_ready_o, 1);

      // flush discards a pending response
      accept(3'd4, 1'b0, 64'd9, 64'd0, 5'd22);
      @(negedge clk);
      chk("pending_valid", resp_valid_o, 1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_done_valid", resp_valid_o, 0);
      chk("flush_done_ready", req_ready_o, 1);

      // reset in mid-CALC, after leaving a nonzero result behind
      do_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd19, 0, 64'd15);
      accept(3'd1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd23);
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset("mid_reset");
      rst = 1'b1;

      // recovery after reset
      do_op(3'd7, 1'b0, 64'd100, 64'd7, 5'd24, 1, 64'd2);
      do_op(3'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd25, 0,
            ref_res(3'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ysyx_22040237_mdu_ctrl.md
# ysyx_22040237_mdu_ctrl

Multi-cycle sequencer for the RV64M multiply/divide instructions, placed beside the single-cycle EXU. It accepts one operation at a time over a valid/ready handshake and runs an iterative shift-add multiplier or restoring divider over 64 or 32 iterations. It applies RISC-V sign and special-case rules and returns the result with its destination register over a second handshake. While it is busy, the front end is stalled through `busy_o`.

## Interface
- `XLEN`, 64, datapath width. Only 64 is supported.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid_i` input 1: an operation is presented.
- `req_ready_o` output 1: the block can accept an operation. High only in IDLE.
- `op_i` input 3: M-extension funct3. 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `wop_i` input 1: word variant (mulw/divw/divuw/remw/remuw). Ignored for op 001–011.
- `op1_i`, `op2_i` input 64: rs1 and rs2 values.
- `rd_idx_i` input 5: destination register.
- `flush_i` input 1: abort the current operation.
- `resp_valid_o` output 1: the result is valid.
- `resp_ready_i` input 1: the consumer takes the result.
- `res_o` output 64: the result.
- `rd_idx_o` output 5: the captured destination register.
- `rd_wr_en_o` output 1: equals `resp_valid_o`.
- `busy_o` output 1: high in every state except IDLE.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** an operation is accepted when `req_valid_i && req_ready_o` at a clock edge. On acceptance the block captures `op_i`, `wop_i`, `rd_idx_i` and the prepared operands.
- **Operand preparation:**
  - W ops: the operands are taken from bits [31:0]. Signed ops sign-extend them, unsigned ops zero-extend them. The iteration count N is 32.
  - All other ops: N is 64.
  - Signed operands are converted to magnitudes, and the result-sign flags are latched:
    - mul/mulh: sign = s1^s2.
    - mulhsu: only op1 is signed.
    - div: quotient sign = s1^s2.
    - rem: remainder sign = s1.
- **Multiply:**
  - 128-bit accumulator plus a shift register for the multiplier.
  - Each CALC cycle adds the shifted multiplicand when the current multiplier bit is 1, then shifts.
- **Divide:**
  - Restoring division: one quotient bit per CALC cycle.
  - Each cycle the partial remainder is shifted left, the divisor is trial-subtracted, and the step is kept if the result is non-negative.
- **Special cases** are detected at accept. They skip CALC and FIX and go IDLE→DONE:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative value ÷ −1, checked at the W width for W ops): quotient = dividend; remainder = 0.
- **FIX state:**
  - Applies two's-complement negation according to the latched sign flags. The negation is 128-bit for mulh/mulhsu.
  - Selects the result: product[63:0] for mul, product[127:64] for mulh*, quotient for div*, remainder for rem*.
  - W ops sign-extend bit 31 of the selected result to 64 bits.
- **DONE state:**
  - `resp_valid_o` is held high.
  - `res_o` and `rd_idx_o` are stable until `resp_valid_o && resp_ready_i`. The state then goes to IDLE.
- **Flush:**
  - When `flush_i` is high in any state, the next state is IDLE.
  - No response is produced. A pending DONE is discarded.
  - If flush and accept occur in the same cycle, flush wins and nothing is accepted.
- **Reset:** when `rst` is 0, the next state is IDLE and the internal counter and accumulators are cleared, including in mid-operation.

## Timing
- **Reset values:** `req_ready_o`=1, `resp_valid_o`=0, `busy_o`=0, `res_o`=0, `rd_idx_o`=0, `rd_wr_en_o`=0.
- **Normal latency:** an operation accepted at edge T occupies CALC during cycles T+1..T+N and FIX at T+N+1. `resp_valid_o` is first high at T+N+2:
  - 64-bit ops: T+66.
  - W ops: T+34.
- **Special-case latency:** `resp_valid_o` is high at T+1.
- **Counter:** a 6-bit iteration counter is loaded with N−1 and decrements each CALC cycle. CALC→FIX when the counter reaches 0.
- **Back-to-back:** the next accept is possible no earlier than the cycle after the response handshake. There is no overlap.
- **Outputs:** `res_o` and `rd_idx_o` are registered. There is no combinational path from any input to any output, except that `req_ready_o` depends only on the state.

## Test plan
- **mul:** mul, op1=3, op2=−5 (0xFFFFFFFFFFFFFFFB) → `res_o`=0xFFFFFFFFFFFFFFF1, `resp_valid_o` first high at T+66, `rd_idx_o` equals the captured index.
- **mulhu:** mulhu, op1=op2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. mulh with the same operands → 0.
- **divide by zero:** div 7/0 → 0xFFFFFFFFFFFFFFFF at T+1. rem 7/0 → 7. divuw 5/0 → 0xFFFFFFFFFFFFFFFF.
- **signed overflow:** div 0x8000000000000000/−1 → 0x8000000000000000; rem → 0. divw 0x80000000/−1 → 0xFFFFFFFF80000000. All at T+1.
- **W ops:** divw −7/2 → 0xFFFFFFFFFFFFFFFD; remw −7/2 → 0xFFFFFFFFFFFFFFFF. Both at T+34.
- **backpressure, flush, reset:**
  - Hold `resp_ready_i`=0 for 5 cycles in DONE → `res_o` stable and `req_ready_o`=0.
  - Assert `flush_i` at CALC cycle 10 → IDLE next cycle and no `resp_valid_o`.
  - Drive `rst`=0 mid-CALC → all outputs at their reset values on the next edge.
